// File: rtl/audio_envelope_tracker.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : audio_envelope_tracker                                          |
// | Pops right-channel samples from the codec read_ready/read handshake,     |
// | tracks peak |sample| and hysteretic rising zero crossings per window     |
// | (window closed by the 60 Hz tick) and publishes the per-window results.  |
// | Optional feature macro: DC_REMOVE_EN (running-mean DC removal before     |
// | analysis; adds one cycle to sample processing).                          |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module audio_envelope_tracker #(
  parameter int                DATA_W = 24,
  parameter int                CNT_W  = 15,
  parameter logic [DATA_W-1:0] HYST   = 24'h000800,
  parameter int                DC_SH  = 8
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              read_ready,
  input  logic [DATA_W-1:0] readdata,
  output logic              read,
  input  logic              tick,
  output logic [DATA_W-1:0] peak,
  output logic [CNT_W-1:0]  zc_count,
  output logic [1:0]        level,
  output logic              result_valid
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ACK   = 3'd1;
  localparam logic [2:0] S_PROC  = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
`ifdef DC_REMOVE_EN
  localparam logic [2:0] S_PROC2 = 3'd4;
`endif

  localparam logic [DATA_W-1:0] MAX_POS = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] MIN_NEG = {1'b1, {(DATA_W-1){1'b0}}};
  localparam logic [DATA_W-1:0] LVL1_TH = DATA_W'(1) << (DATA_W-5);
  localparam logic [DATA_W-1:0] LVL2_TH = DATA_W'(1) << (DATA_W-3);
  localparam logic [DATA_W-1:0] LVL3_TH = DATA_W'(1) << (DATA_W-2);

  // The DC tracker sign-extends the difference into a wider register.
  if (DC_SH < 2) begin : g_bad_dc_sh
    $error("audio_envelope_tracker: DC_SH must be at least 2");
  end

  logic [2:0]        state;
  logic [2:0]        state_nx;
  logic              fold;        // analysis sample is folded this cycle
  logic [DATA_W-1:0] s_reg;       // sample popped from the codec
  logic [DATA_W-1:0] an;          // sample as seen by the analysis path
  logic [DATA_W-1:0] an_abs;
  logic              above;
  logic              below;
  logic [DATA_W-1:0] pk_acc;
  logic [DATA_W-1:0] pk_nx;
  logic [CNT_W-1:0]  zc_acc;
  logic [CNT_W-1:0]  zc_nx;
  logic              sign_pos;    // 1 once the signal went above +HYST
  logic              sign_nx;
  logic [1:0]        lvl_nx;

  // State register.
  always_ff @(posedge CLOCK_50) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic: one pop per read_ready assertion.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (read_ready) state_nx = S_ACK;
      S_ACK:   state_nx = S_PROC;
`ifdef DC_REMOVE_EN
      S_PROC:  state_nx = S_PROC2;
      S_PROC2: state_nx = S_WAIT;
`else
      S_PROC:  state_nx = S_WAIT;
`endif
      S_WAIT:  if (!read_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Output decode of the state register.
  always_comb begin
    read = (state == S_ACK);
`ifdef DC_REMOVE_EN
    fold = (state == S_PROC2);
`else
    fold = (state == S_PROC);
`endif
  end

  // Capture the codec sample during the acknowledge cycle.
  always_ff @(posedge CLOCK_50) begin
    if (reset)               s_reg <= '0;
    else if (state == S_ACK) s_reg <= readdata;
  end

`ifdef DC_REMOVE_EN
  localparam int DC_W = DATA_W + DC_SH;

  logic [DC_W-1:0]   dc;
  logic [DATA_W-1:0] dc_mean;
  logic [DATA_W:0]   diff;
  logic [DATA_W-1:0] diff_sat;
  logic [DATA_W-1:0] an_reg;

  // Sample minus the running mean; the mean is dc>>>DC_SH, which fits DATA_W.
  always_comb begin
    dc_mean = dc[DC_W-1:DC_SH];
    diff    = {s_reg[DATA_W-1], s_reg} - {dc_mean[DATA_W-1], dc_mean};
    if (diff[DATA_W] != diff[DATA_W-1]) diff_sat = diff[DATA_W] ? MIN_NEG : MAX_POS;
    else                                diff_sat = diff[DATA_W-1:0];
  end

  // First processing cycle: update the mean tracker and stage the DC-free sample.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      dc     <= '0;
      an_reg <= '0;
    end else if (state == S_PROC) begin
      an_reg <= diff_sat;
      dc     <= dc + {{(DC_SH-1){diff[DATA_W]}}, diff};
    end
  end

  assign an = an_reg;
`else
  assign an = s_reg;
`endif

  // Fold the analysis sample into the window accumulators.
  always_comb begin
    if (an == MIN_NEG)      an_abs = MAX_POS;
    else if (an[DATA_W-1])  an_abs = -an;
    else                    an_abs = an;
    above   = $signed(an) > $signed(HYST);
    below   = $signed(an) < -$signed(HYST);
    pk_nx   = pk_acc;
    zc_nx   = zc_acc;
    sign_nx = sign_pos;
    if (fold) begin
      if (an_abs > pk_acc) pk_nx = an_abs;
      if (above) begin
        sign_nx = 1'b1;
        if (!sign_pos && (zc_acc != {CNT_W{1'b1}})) zc_nx = zc_acc + 1'b1;
      end else if (below) begin
        sign_nx = 1'b0;
      end
    end
  end

  // Coarse bar derived from the peak about to be published.
  always_comb begin
    if (pk_nx < LVL1_TH)      lvl_nx = 2'd0;
    else if (pk_nx < LVL2_TH) lvl_nx = 2'd1;
    else if (pk_nx < LVL3_TH) lvl_nx = 2'd2;
    else                      lvl_nx = 2'd3;
  end

  // Window accumulators and published results; sign flag spans windows.
  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      pk_acc       <= '0;
      zc_acc       <= '0;
      sign_pos     <= 1'b0;
      peak         <= '0;
      zc_count     <= '0;
      level        <= 2'd0;
      result_valid <= 1'b0;
    end else begin
      sign_pos     <= sign_nx;
      result_valid <= tick;
      if (tick) begin
        peak     <= pk_nx;
        zc_count <= zc_nx;
        level    <= lvl_nx;
        pk_acc   <= '0;
        zc_acc   <= '0;
      end else begin
        pk_acc <= pk_nx;
        zc_acc <= zc_nx;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_audio_envelope_tracker.sv
`default_nettype none
// Bench for audio_envelope_tracker: directed handshake/reset steps, directed
// arithmetic windows and randomized windows against a behavioural model.
module tb_audio_envelope_tracker;

  localparam longint HYST = 'h800;
`ifdef DC_REMOVE_EN
  localparam int PROC_CYC = 2;
`else
  localparam int PROC_CYC = 1;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        read_ready;
  logic [23:0] readdata;
  logic        read;
  logic        tick;
  logic [23:0] peak;
  logic [14:0] zc_count;
  logic [1:0]  level;
  logic        result_valid;

  int     n_pass  = 0;
  int     n_total = 0;
  longint m_pk;
  longint m_zc;
  bit     m_sign;

  always #5 clk = ~clk;

  audio_envelope_tracker dut (
    .CLOCK_50    (clk),
    .reset       (reset),
    .read_ready  (read_ready),
    .readdata    (readdata),
    .read        (read),
    .tick        (tick),
    .peak        (peak),
    .zc_count    (zc_count),
    .level       (level),
    .result_valid(result_valid)
  );

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference model: per-window peak magnitude and hysteretic rising crossings.
  task automatic m_reset();
    m_pk = 0; m_zc = 0; m_sign = 0;
  endtask

  task automatic m_fold(input logic [23:0] v);
    longint s, a;
    s = longint'($signed(v));
    a = (s < 0) ? -s : s;
    if (a > 'h7FFFFF) a = 'h7FFFFF;
    if (a > m_pk) m_pk = a;
    if (s > HYST) begin
      if (!m_sign && m_zc < 32767) m_zc = m_zc + 1;
      m_sign = 1;
    end else if (s < -HYST) begin
      m_sign = 0;
    end
  endtask

  function automatic longint m_level(input longint pk);
    if (pk < (64'd1 << 19)) return 0;
    if (pk < (64'd1 << 21)) return 1;
    if (pk < (64'd1 << 22)) return 2;
    return 3;
  endfunction

  // Called right after the closing edge: results visible, pulse lasts one cycle.
  task automatic close_check(input string tag);
    chk({tag, "_valid"}, result_valid, 1);
    chk({tag, "_peak"},  peak,     m_pk);
    chk({tag, "_zc"},    zc_count, m_zc);
    chk({tag, "_level"}, level,    m_level(m_pk));
    m_pk = 0;
    m_zc = 0;
    step();
    chk({tag, "_valid_drop"}, result_valid, 0);
  endtask

  task automatic do_tick(input string tag);
    tick = 1;
    step();
    tick = 0;
    close_check(tag);
  endtask

  // One codec transaction; optionally strobe tick on the cycle the sample folds.
  task automatic send(input logic [23:0] v, input bit tick_in);
    int n;
    bit seen;
    read_ready = 1;
    readdata   = v;
    seen = 0;
    n = 0;
    while (!seen && n < 8) begin
      step();
      n++;
      if (read === 1'b1) seen = 1;
    end
    chk("read_latency", n, 1);
    step();
    read_ready = 0;
    readdata   = 24'($urandom);
    tick       = tick_in;
    repeat (PROC_CYC) step();
    tick = 0;
    m_fold(v);
    if (tick_in) close_check("proc_tick");
    else         step();
  endtask

  initial begin
    int cnt, first, nsmp;
    logic [23:0] v;

    reset = 1; read_ready = 0; readdata = '0; tick = 0;
    m_reset();
    step(); step();
    reset = 0;
    chk("rst_read",  read, 0);
    chk("rst_peak",  peak, 0);
    chk("rst_zc",    zc_count, 0);
    chk("rst_level", level, 0);
    chk("rst_valid", result_valid, 0);

    // read_ready held high for 20 cycles: a single pop one cycle later.
    read_ready = 1;
    readdata   = 24'h300000;
    cnt = 0;
    first = -1;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (read === 1'b1) begin
        cnt++;
        if (first < 0) first = i;
      end
    end
    chk("hold_read_count",   cnt, 1);
    chk("hold_read_latency", first, 1);
    read_ready = 0;
    step(); step();
    m_fold(24'h300000);
    do_tick("hold");

    // Reset while in ACK: everything clears and the popped sample is dropped.
    read_ready = 1;
    readdata   = 24'h7FFFFF;
    step();
    chk("midack_read_pre", read, 1);
    reset = 1;
    step();
    reset = 0;
    read_ready = 0;
    chk("midack_read",  read, 0);
    chk("midack_peak",  peak, 0);
    chk("midack_zc",    zc_count, 0);
    chk("midack_level", level, 0);
    chk("midack_valid", result_valid, 0);
    m_reset();
    step();
    do_tick("midack_drop");

`ifndef DC_REMOVE_EN
    // Full-swing alternation well outside the hysteresis band.
    for (int i = 0; i < 50; i++) begin
      send(24'h100000, 0);
      send(24'hF00000, 0);
    end
    do_tick("alt");
    chk("alt_zc_abs",    zc_count, 50);
    chk("alt_peak_abs",  peak, 24'h100000);
    chk("alt_level_abs", level, 1);

    // Alternation inside the hysteresis band counts nothing.
    for (int i = 0; i < 50; i++) begin
      send(24'h000400, 0);
      send(24'hFFFC00, 0);
    end
    do_tick("inband");
    chk("inband_zc_abs", zc_count, 0);
    chk("inband_peak_abs", peak, 24'h000400);

    // Most negative sample saturates; then an empty window.
    send(24'h800000, 0);
    do_tick("minneg");
    chk("minneg_peak_abs",  peak, 24'h7FFFFF);
    chk("minneg_level_abs", level, 3);
    do_tick("empty");
    chk("empty_peak_abs", peak, 0);

    // Tick on the same cycle as a folded sample includes that sample.
    send(24'h0C0000, 0);
    send(24'h123456, 1);
    chk("proc_tick_peak_abs", peak, 24'h123456);

    // Randomized windows.
    for (int w = 0; w < 14; w++) begin
      nsmp = $urandom_range(0, 7);
      for (int k = 0; k < nsmp; k++) begin
        case ($urandom_range(0, 3))
          0: v = 24'($urandom_range(0, 'h1000)) - 24'h000800;
          1: v = 24'($urandom);
          2: v = $urandom_range(0, 1) ? 24'($urandom_range('h801, 'h7FFFFF))
                                      : -24'($urandom_range('h801, 'h7FFFFF));
          default: v = $urandom_range(0, 1) ? 24'h800000 : 24'h7FFFFF;
        endcase
        send(v, (k == nsmp - 1) && ($urandom_range(0, 1) == 1));
      end
      if (result_valid !== 1'b0 || nsmp == 0 || $urandom_range(0, 1) == 1) begin
        step();
        do_tick("rand");
      end
    end
`else
    // Constant input: the DC tracker removes it, leaving a tiny residual.
    for (int i = 0; i < 4096; i++) begin
      send(24'h200000, 0);
      if ((i % 512) == 511) begin
        tick = 1;
        step();
        tick = 0;
        chk("dc_valid", result_valid, 1);
        step();
      end
    end
    chk("dc_peak_small", (peak < 24'h010000), 1);
    chk("dc_zc", zc_count, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
